// File: rtl/lc3_pipe_ctrl_v2.sv
// lc3_pipe_ctrl_v2: LC-3 sequencing controller with memory stage, indirect access and a timeout watchdog.
module lc3_pipe_ctrl_v2 #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200,
  parameter int IND_EN  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        stall,
  output logic        illegal_op,
  output logic        timeout_err
);
  typedef enum logic [2:0] {UPD, FETCH, DEC, EXE, MEM, WB, ERR} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0] r_mem, w_mem;
  logic r_br, r_store;
  logic [3:0] w_op;
  logic w_ind, w_mem_op, w_alu, w_illegal, w_taken, w_timeout, w_unused;
  assign w_op      = IR[15:12];
  assign w_ind     = w_op == 4'b1010 || w_op == 4'b1011;
  assign w_mem_op  = (w_op inside {4'b0010, 4'b0110, 4'b0011, 4'b0111}) || (w_ind && IND_EN != 0);
  assign w_alu     = w_op inside {4'b0001, 4'b0101, 4'b1001, 4'b1110, 4'b0100};
  assign w_illegal = !(w_mem_op || w_alu || w_op == 4'b0000 || w_op == 4'b1100);
  assign w_taken   = w_op == 4'b0000 ? |(psr & IR[11:9]) : (w_op == 4'b1100 || w_op == 4'b0100);
  assign w_timeout = r_cnt == CNT_W'(TIMEOUT);
  assign w_unused  = ^IR[8:0];
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_mem  = r_mem;
    case (r_state)
      UPD: begin
        w_next = FETCH;
        w_cnt  = '0;
      end
      FETCH: begin
        w_next = complete_instr ? DEC : (w_timeout ? ERR : FETCH);
        w_cnt  = complete_instr ? '0 : r_cnt + CNT_W'(1);
      end
      DEC: w_next = EXE;
      EXE: begin
        w_next = w_mem_op ? MEM : (w_alu ? WB : UPD);
        w_cnt  = '0;
        w_mem  = !w_mem_op ? 2'd3 : (w_ind ? 2'd1 : (IR[12] ? 2'd2 : 2'd0));
      end
      MEM: begin
        // The first completion of an indirect access only moves to the data phase.
        if (complete_data) begin
          w_cnt  = '0;
          w_mem  = r_mem == 2'd1 ? (r_store ? 2'd2 : 2'd0) : 2'd3;
          w_next = r_mem == 2'd1 ? MEM : (r_store ? UPD : WB);
        end else begin
          w_cnt  = r_cnt + CNT_W'(1);
          w_mem  = w_timeout ? 2'd3 : r_mem;
          w_next = w_timeout ? ERR : MEM;
        end
      end
      WB:  w_next = UPD;
      ERR: w_next = ERR;
      default: w_next = UPD;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= UPD;
      r_cnt   <= '0;
      r_mem   <= 2'd3;
      r_br    <= 1'b0;
      r_store <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_mem   <= w_mem;
      r_br    <= r_state == EXE ? w_taken : (r_state == UPD ? 1'b0 : r_br);
      r_store <= r_state == EXE ? IR[12] : r_store;
    end
  end
  // Outputs are forced quiet while reset is held, whatever state is still registered.
  assign enable_updatePC  = !reset && r_state == UPD;
  assign enable_fetch     = !reset && r_state == FETCH;
  assign enable_decode    = !reset && r_state == DEC;
  assign enable_execute   = !reset && r_state == EXE;
  assign enable_writeback = !reset && r_state == WB;
  assign stall            = !reset && r_state == MEM;
  assign timeout_err      = !reset && r_state == ERR;
  assign illegal_op       = !reset && r_state == EXE && w_illegal;
  assign br_taken         = !reset && r_br;
  assign mem_state        = reset ? 2'd3 : r_mem;
endmodule

// File: doc/lc3_pipe_ctrl_v2.md
Name: lc3_pipe_ctrl_v2

Overview:
- Next-generation LC-3 instruction-sequencing controller with a timeout watchdog on every memory wait.
- Drives per-stage enables (updatePC, fetch, decode, execute, writeback), resolves branches and sequences data-memory accesses, including indirect LDI/STI.
- Sits between the fetch/decode/execute/writeback datapath blocks and the instruction/data memory handshakes.
- Adds over the previous controller: an explicit memory stage with stall, a parametrised timeout watchdog with a sticky error state, optional indirect access, and registered branch resolution.

Parameters:
- CNT_W, 8, width of the wait/timeout counter.
- TIMEOUT, 200, wait cycles in FETCH or MEM before a timeout error; must be < 2**CNT_W.
- IND_EN, 1, 1 = LDI/STI execute as two-phase indirect; 0 = LDI/STI are illegal ops.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- IR  in  16  instruction currently held in execute.
- complete_instr  in  1  instruction memory done (single-cycle pulse).
- complete_data  in  1  data memory done (single-cycle pulse).
- psr  in  3  N,Z,P flags.
- enable_updatePC  out  1  PC update strobe.
- enable_fetch  out  1  fetch active.
- enable_decode  out  1  decode strobe.
- enable_execute  out  1  execute strobe.
- enable_writeback  out  1  register-file write strobe.
- br_taken  out  1  PC mux select for branch/jump target.
- mem_state  out  2  0 = read, 1 = indirect-address read, 2 = write, 3 = idle.
- stall  out  1  high while in MEM.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset:
  - State goes to UPD; counter = 0.
  - All enables, br_taken, stall, illegal_op and timeout_err are 0; mem_state = 3.
  - Reset mid-wait aborts the access immediately.
- Main FSM (registered state, Moore outputs):
  - UPD: enable_updatePC=1 for 1 cycle -> FETCH.
  - FETCH: enable_fetch=1. On complete_instr -> DEC; else stay and increment counter.
  - DEC: enable_decode=1 for 1 cycle -> EXE.
  - EXE: enable_execute=1 for 1 cycle. Classify IR[15:12]:
    - Memory ops LD 0010, LDR 0110, ST 0011, STR 0111, LDI 1010, STI 1011 -> MEM.
    - ADD 0001, AND 0101, NOT 1001, LEA 1110, JSR 0100 -> WB.
    - BR 0000, JMP 1100 -> UPD.
    - Any other opcode (or LDI/STI when IND_EN=0): illegal_op pulses in the EXE cycle -> UPD.
  - MEM: stall=1; memory sub-FSM runs. On final complete_data: loads -> WB, stores -> UPD.
  - WB: enable_writeback=1 for 1 cycle -> UPD.
  - ERR: all enables 0, mem_state=3, timeout_err=1. Exit only via reset.
- Memory sub-FSM (mem_state is a registered output, valid from the first MEM cycle):
  - LD/LDR: 0 until complete_data.
  - ST/STR: 2 until complete_data.
  - LDI: 1 until complete_data, then 0 until complete_data.
  - STI: 1, then 2.
  - mem_state returns to 3 in the cycle after the final complete_data.
  - complete_data outside MEM is ignored.
  - complete_instr outside FETCH is ignored.
- Watchdog:
  - Counter clears on entry to FETCH/MEM and on every complete_* pulse.
  - When counter == TIMEOUT with no completion -> ERR on the next edge.
  - A completion arriving in the same cycle the counter reaches TIMEOUT wins; no error.
- Branch:
  - Evaluated in EXE.
  - BR: taken = |(psr & IR[11:9]). BR with nzp=000 is never taken.
  - JMP and JSR are always taken.
  - br_taken is a register, set at the end of EXE and held through the following UPD cycle. It clears on UPD exit, i.e. it is high exactly during that UPD cycle.
  - A JSR writeback precedes UPD, so br_taken stays high across WB and UPD.
- Cycle counts with zero-wait memory:
  - Non-memory ALU op: UPD, FETCH, DEC, EXE, WB = 5 cycles.
  - Branch: 4 cycles.
  - LD: 6 cycles.
  - LDI: 7 cycles.

Test Plan:
- Reset, then ADD (IR=16'h1042) with complete_instr in the 2nd FETCH cycle -> enables sequence UPD, FETCH×2, DEC, EXE, WB; mem_state stays 3; br_taken=0.
- psr=3'b010, IR=16'h0405 (BRz) -> br_taken=1 only in the UPD cycle. Repeat with psr=3'b100 -> br_taken=0 throughout.
- LDI (IR=16'hA201), complete_data after 3 then 2 MEM cycles -> mem_state 1,1,1,0,0 then 3; stall high for 5 cycles; then one WB cycle.
- STI with IND_EN=0 -> illegal_op pulse in EXE, no MEM entry, next state UPD.
- TIMEOUT=4, ST (IR=16'h3001), no complete_data -> ERR after 5 MEM cycles; timeout_err stays 1 and all enables 0 until reset, then restart at UPD.
- Reset asserted during the 2nd MEM cycle of LD -> next cycle is UPD; mem_state=3; stall=0.
